// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit_if
// Brief    : Fetch-stage bundle: control, imem request/response and decode output.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               stop;
    logic               branch_valid;
    logic [PC_W-1:0]    branch_target;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               halted;

    // Fetch unit side
    modport master (
        input  stop, branch_valid, branch_target, imem_ready, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr, instr_pc, instr_valid, halted
    );

    // Environment side (imem + decode + control)
    modport slave (
        output stop, branch_valid, branch_target, imem_ready, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, halted
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Program counter / fetch stage with a 1-entry output register,
//            stall, backpressure, branch redirect and PC wrap-around.
// Options  : FETCH_HALT_EN - halt fetching after delivering HALT_INSTR
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter int                 PC_W       = 8,
    parameter int                 INSTR_W    = 16,
    parameter int unsigned        PC_STEP    = 1,
    parameter logic [PC_W-1:0]    RESET_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF
) (
    input  wire logic            clk,
    input  wire logic            reset,
    pc_fetch_unit_if.master      bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [PC_W-1:0] c_pc_step = PC_W'(PC_STEP);

`ifdef FETCH_HALT_EN
    localparam logic c_halt_en = 1'b1;
`else
    localparam logic c_halt_en = 1'b0;
`endif

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_instr_pc;
    logic               r_instr_valid;

    logic w_out_free;
    logic w_req;
    logic w_capture;
    logic w_consume;
    logic w_halt_hit;

    assign w_out_free = !r_instr_valid || bus.instr_ready;
    assign w_req      = (r_state == S_RUN) && !bus.stop && !bus.branch_valid
                        && w_out_free && !reset;
    assign w_capture  = w_req && bus.imem_ready;
    assign w_consume  = r_instr_valid && bus.instr_ready;
    assign w_halt_hit = c_halt_en && w_capture && (bus.imem_rdata == HALT_INSTR);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a redirect always lands in S_RUN
    always_comb begin
        w_state_nxt = r_state;
        if (bus.branch_valid) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_RUN;
                S_RUN:   w_state_nxt = w_halt_hit ? S_HALT : S_RUN;
                S_HALT:  w_state_nxt = S_HALT;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // PC and output entry; a redirect flushes the entry but keeps its data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else if (bus.branch_valid) begin
            r_pc          <= bus.branch_target;
            r_instr_valid <= 1'b0;
        end else if (w_capture) begin
            r_instr       <= bus.imem_rdata;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_pc          <= r_pc + c_pc_step;
        end else if (w_consume) begin
            r_instr_valid <= 1'b0;
        end
    end

`ifdef FETCH_HALT_EN
    logic r_halted;

    always_ff @(posedge clk) begin
        if (reset || bus.branch_valid) begin
            r_halted <= 1'b0;
        end else if (w_halt_hit) begin
            r_halted <= 1'b1;
        end
    end

    assign bus.halted = r_halted;
`else
    assign bus.halted = 1'b0;
`endif

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Directed + randomized bench for pc_fetch_unit against a
//            cycle-level reference model of the fetch stage.
// Options  : FETCH_HALT_EN - also exercises halt-on-opcode
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam int          PC_W    = 8;
    localparam int          INSTR_W = 16;
    localparam logic [15:0] c_halt  = 16'hFFFF;
`ifdef FETCH_HALT_EN
    localparam bit c_halt_en = 1'b1;
`else
    localparam bit c_halt_en = 1'b0;
`endif

    logic clk;
    logic reset;

    pc_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    pc_fetch_unit #(
        .PC_W       (PC_W),
        .INSTR_W    (INSTR_W),
        .PC_STEP    (1),
        .RESET_PC   (8'h00),
        .HALT_INSTR (c_halt)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory answers combinationally at the requested address
    logic [INSTR_W-1:0] mem [256];
    assign bus.imem_rdata = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural view of the fetch stage
    logic [7:0]  m_pc     = 8'h00;
    logic [15:0] m_instr  = 16'h0000;
    logic [7:0]  m_ipc    = 8'h00;
    bit          m_vld    = 1'b0;
    bit          m_halted = 1'b0;
    bit          m_started = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit rs, input bit st, input bit br, input logic [7:0] tg,
                         input bit ir, input bit od);
        bit exp_req;
        @(negedge clk);
        reset              = rs;
        bus.stop           = st;
        bus.branch_valid   = br;
        bus.branch_target  = tg;
        bus.imem_ready     = ir;
        bus.instr_ready    = od;
        #1;
        exp_req = !rs && m_started && !m_halted && !st && !br && (!m_vld || od);
        check("imem_req",    32'(bus.imem_req),    32'(exp_req));
        check("imem_addr",   32'(bus.imem_addr),   32'(m_pc));
        check("instr_valid", 32'(bus.instr_valid), 32'(m_vld));
        check("instr",       32'(bus.instr),       32'(m_instr));
        check("instr_pc",    32'(bus.instr_pc),    32'(m_ipc));
        check("halted",      32'(bus.halted),      32'(m_halted));
        if (rs) begin
            m_pc = 8'h00; m_instr = 16'h0000; m_ipc = 8'h00;
            m_vld = 1'b0; m_halted = 1'b0; m_started = 1'b0;
        end else if (br) begin
            m_pc = tg; m_vld = 1'b0; m_halted = 1'b0; m_started = 1'b1;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (exp_req && ir) begin
            m_instr = mem[m_pc];
            m_ipc   = m_pc;
            m_vld   = 1'b1;
            if (c_halt_en && mem[m_pc] == c_halt) m_halted = 1'b1;
            m_pc    = m_pc + 8'd1;
        end else if (m_vld && od) begin
            m_vld = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
        mem[8'h25] = c_halt;
        reset = 1'b1;
        bus.stop = 1'b0; bus.branch_valid = 1'b0; bus.branch_target = 8'h00;
        bus.imem_ready = 1'b1; bus.instr_ready = 1'b1;

        // Reset, idle cycle, streaming fetch 0..3
        cycle(1, 0, 0, 8'h00, 1, 1);
        cycle(1, 0, 0, 8'h00, 1, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 8'h00, 1, 1);
        // Stall at pc=4, then resume
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h00, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 1, 1);
        // Backpressure for 4 cycles, then release
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 1, 1);
        // imem not ready: same address repeats
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 8'h00, 0, 1);
        // Redirect to 0x40 while valid and imem ready
        cycle(0, 0, 1, 8'h40, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 1, 1);
        // Wrap-around from 0xFF to 0x00
        cycle(0, 0, 1, 8'hFC, 1, 1);
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 8'h00, 1, 1);
        // Reset in the middle of a stream
        cycle(1, 0, 0, 8'h00, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 1, 1);
        // Halt word at 0x25 (only halts when the option is built in), then redirect
        cycle(0, 0, 1, 8'h23, 1, 1);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 8'h00, 1, 1);
        cycle(0, 0, 1, 8'h10, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 1, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 19) == 0, 8'($urandom),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
